// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FIFO occupancy, response entry,
// and the default LED register address.
package dmem_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   typedef struct packed {
      logic [31:0] rdata;
   } rsp_entry_t;

   localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_FFFC;

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Two-entry response FIFO; entry 0 is always the head.
module dmem_rsp_fifo
   import dmem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  rsp_entry_t push_data,
   input  logic       pop,
   output logic       valid,
   output rsp_entry_t head,
   output occ_e       occ
);

   occ_e       occ_q, occ_d;
   rsp_entry_t e0_q, e1_q;
   logic       pop_eff;

   assign valid   = (occ_q != OCC_EMPTY);
   assign pop_eff = pop && valid;
   assign occ     = occ_q;
   assign head    = valid ? e0_q : '0;

   always_comb begin
      occ_d = occ_q;
      unique case (occ_q)
         OCC_EMPTY: if (push) occ_d = OCC_ONE;
         OCC_ONE: begin
            if (push && !pop_eff)      occ_d = OCC_FULL;
            else if (pop_eff && !push) occ_d = OCC_EMPTY;
         end
         OCC_FULL:  if (pop_eff && !push) occ_d = OCC_ONE;
         default:   occ_d = OCC_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) occ_q <= OCC_EMPTY;
      else        occ_q <= occ_d;
   end

   // Simultaneous push/pop shifts the queue so ordering is kept at fixed occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q <= '0;
         e1_q <= '0;
      end else begin
         unique case (occ_q)
            OCC_EMPTY: if (push) e0_q <= push_data;
            OCC_ONE: begin
               if (push && pop_eff) e0_q <= push_data;
               else if (push)       e1_q <= push_data;
            end
            OCC_FULL: begin
               if (pop_eff) begin
                  e0_q <= e1_q;
                  if (push) e1_q <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a valid/ready request/response pair.
// Optional MMIO LED register enabled by defining DMEM_MMIO_LED_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH    = 1024,
   parameter logic [31:0] LED_ADDR = LED_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [31:0] led
);

   localparam int unsigned IDXW = $clog2(DEPTH);

   logic [31:0]     mem [DEPTH];
   logic [IDXW-1:0] idx;
   logic            accept;
   logic            led_hit;
   logic            mem_we;
   logic [31:0]     led_q;
   logic [31:0]     rd_word_q;
   logic            run_q;
   logic            inflight_q;
   occ_e            occ;
   rsp_entry_t      push_data;
   rsp_entry_t      head;
   logic            unused_bits;

   assign idx         = req_addr[IDXW+1:2];
   assign accept      = req_valid && req_ready;
   assign mem_we      = accept && req_wen && !led_hit;
   assign unused_bits = ^{req_addr[31:IDXW+2], req_addr[1:0], LED_ADDR};

`ifdef DMEM_MMIO_LED_EN
   assign led_hit = (req_addr[31:2] == LED_ADDR[31:2]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q <= '0;
      end else if (accept && req_wen && led_hit) begin
         for (int unsigned b = 0; b < 4; b++)
            if (req_be[b]) led_q[8*b +: 8] <= req_wdata[8*b +: 8];
      end
   end
`else
   assign led_hit = 1'b0;
   assign led_q   = '0;
`endif

   assign led = led_q;

   // Array has no reset so its contents survive rst_n
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < 4; b++)
            if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
      if (accept)
         rd_word_q <= req_wen ? '0 : (led_hit ? led_q : mem[idx]);
   end

   // Every accepted request spends one cycle in flight so writes and reads stay ordered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q      <= 1'b0;
         inflight_q <= 1'b0;
      end else begin
         run_q      <= 1'b1;
         inflight_q <= accept;
      end
   end

   assign req_ready = run_q &&
                      ((occ == OCC_EMPTY) || ((occ == OCC_ONE) && !inflight_q));

   assign push_data.rdata = rd_word_q;

   dmem_rsp_fifo u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (push_data),
      .pop       (rsp_ready),
      .valid     (rsp_valid),
      .head      (head),
      .occ       (occ)
   );

   assign rsp_rdata = head.rdata;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the array (power of two).
REQ-002 SHALL have parameter LED_ADDR, default 32'h0000_FFFC, meaning the byte address of the LED register.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address; bits [1:0] ignored.
REQ-008 SHALL have port req_wen, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_be, input, 4 bits: byte-lane enables for writes; bit i selects bits [8i+7:8i].
REQ-010 SHALL have port req_wdata, input, 32 bits: write data.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: read data; 0 for write acknowledgements.
REQ-014 SHALL have port led, output, 32 bits: the LED register value.

Function
REQ-015 Handshake: a request is accepted when req_valid && req_ready; a response is consumed when rsp_valid && rsp_ready.
REQ-016 Every accepted request, read or write, SHALL produce exactly one response, in acceptance order.
REQ-017 Read latency SHALL be one cycle: for a request accepted at edge N, the earliest rsp_valid is after edge N+1.
REQ-018 Responses SHALL go through a 2-entry response FIFO; rsp_valid = FIFO not empty; rsp_rdata = FIFO head.
REQ-019 req_ready SHALL be 1 iff (FIFO occupancy + in-flight read) < 2, so a response is never dropped under back-pressure.
REQ-020 Occupancy states are EMPTY, ONE and FULL; with simultaneous push and pop the occupancy is unchanged and ordering is preserved.
REQ-021 A FIFO pop and a new request acceptance in the same cycle SHALL both take effect.
REQ-022 Word index SHALL be req_addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-023 A write SHALL update only the enabled byte lanes; req_be = 0 SHALL leave memory unchanged but still acknowledge.
REQ-024 A read accepted in the cycle after a write to the same word SHALL return the newly written data.
REQ-025 rsp_valid and rsp_rdata SHALL stay stable while rsp_valid && !rsp_ready.

Reset
REQ-026 rst_n low SHALL immediately clear the FIFO, the in-flight flag and led; it SHALL force rsp_valid = 0, rsp_rdata = 0 and req_ready = 0.
REQ-027 Reset SHALL NOT clear array contents; any in-flight or queued responses SHALL be discarded.
REQ-028 req_ready SHALL be 1 from the first edge after rst_n is released.

Configuration
REQ-029 Macro DMEM_MMIO_LED_EN defined: a write whose word-aligned address equals LED_ADDR SHALL update led per req_be and SHALL NOT write the array; a read of that address SHALL return led.
REQ-030 Macro DMEM_MMIO_LED_EN undefined: led SHALL be constant 0, and LED_ADDR SHALL decode to the array like any other address.

Structure
REQ-031 A shared package dmem_pkg SHALL hold the FIFO-occupancy enum, the response-entry struct {rdata}, and the default LED_ADDR constant.
REQ-032 The 2-entry response FIFO SHALL be a sub-module named dmem_rsp_fifo; the array and address decode stay in dmem_responder.

Verification
REQ-033 Write 0xDEADBEEF, be=4'hF to 0x10; then read 0x10 with rsp_ready=1 -> write ack rdata=0; read rsp_rdata=0xDEADBEEF one cycle after acceptance.
REQ-034 After REQ-033, write 0x000000AA with be=4'b0001 to 0x10, then read 0x10 -> 0xDEADBEAA.
REQ-035 rsp_ready=0, issue three back-to-back reads -> two are accepted, req_ready=0 on the third; raise rsp_ready -> three responses in order, none lost.
REQ-036 Write 0x12345678 to byte address DEPTH*4+8, then read 0x8 -> 0x12345678 (wrap-around).
REQ-037 With DMEM_MMIO_LED_EN: write 0x5 to LED_ADDR -> led=0x5 and array word unchanged. Without it: led stays 0 and a read of LED_ADDR returns the array data.
REQ-038 Assert rst_n low while two responses are queued -> rsp_valid=0 immediately, led=0; after release no stale responses and prior array data is still readable.
